dac_gain_arbiter: RTL and testbench
===================================

Name: dac_gain_arbiter

Overview:
- Shares the per-column 8-bit DAC gain bus between two requesters: r0 is the host SPI path, r1 is the on-chip calibration engine.
- Accepts one complete NUM_COLS-byte gain burst from the granted requester through a valid/ready handshake and holds it in a local buffer.
- Replays the buffer one byte per clock when the central controller opens its DAC load window.
- Sits between the requesters and the central controller's DAC input.

Parameters:
- NUM_COLS, 128, gain bytes per burst (one per column); must be at least 2.
- DEFAULT_CODE, 8'h80, code driven when no burst is buffered or when a window underruns.
- CW, 8, counter width; must satisfy 2^CW > NUM_COLS.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- r0_valid  input  1  host byte valid.
- r0_data  input  8  host gain byte.
- r0_ready  output  1  host byte accepted this cycle when r0_valid and r0_ready are both high.
- r1_valid  input  1  calibration byte valid.
- r1_data  input  8  calibration gain byte.
- r1_ready  output  1  calibration byte accepted this cycle when r1_valid and r1_ready are both high.
- load_start  input  1  one-cycle pulse from the controller that opens a DAC load window.
- flush  input  1  discard any partial or full buffer and return to IDLE.
- dac_data  output  8  byte presented to the controller's DAC input.
- dac_valid  output  1  high during the NUM_COLS window cycles.
- grant  output  2  one-hot owner of the current burst; 00 means no owner.
- buf_full  output  1  a complete burst is buffered and waiting.
- done  output  1  one-cycle pulse on the last window cycle.
- underrun  output  1  one-cycle pulse when a window is served with DEFAULT_CODE.

Behaviour:
- Reset (synchronous, takes priority over every other input):
  - State goes to IDLE; counters clear; last_grant is set to r1, so r0 wins the first tie.
  - r0_ready, r1_ready, dac_valid, buf_full, done and underrun all go to 0; grant goes to 00; dac_data goes to 8'h00.
  - The buffer contents are don't-care.
- IDLE:
  - If r0_valid and r1_valid are both high, the requester not in last_grant wins; otherwise the single valid requester wins.
  - grant is registered the next cycle; state moves to FILL.
  - If no requester is valid, state stays IDLE.
- FILL:
  - Only the granted requester's ready is high; the other ready stays 0.
  - Each handshake writes buf[wr_cnt] and increments wr_cnt; deasserting valid stalls the fill without penalty.
  - After byte NUM_COLS-1 is accepted, ready drops the next cycle, buf_full goes to 1, last_grant is updated, and state moves to ARMED.
  - grant stays held until the burst is drained or flushed.
- ARMED: wait for load_start. While waiting, ready stays 0 and no new grant is issued.
- DRAIN (buffered window):
  - A load_start in cycle t gives dac_valid=1 and dac_data=buf[k] in cycle t+1+k, for k = 0 to NUM_COLS-1.
  - done pulses in cycle t+NUM_COLS.
  - In cycle t+NUM_COLS+1: dac_valid=0, buf_full=0, grant=00, state returns to IDLE.
  - dac_data holds its last value while dac_valid is 0.
- DEFAULT window (load_start while IDLE or FILL):
  - Serve a DEFAULT window: dac_valid is high for NUM_COLS cycles with dac_data=DEFAULT_CODE, using the same timing as DRAIN.
  - underrun pulses in cycle t+1; done pulses in the last window cycle.
  - A FILL in progress continues in parallel; handshakes remain legal during the window.
- load_start while dac_valid is already high: ignored; the window is not restarted.
- flush:
  - Effective next cycle from any state: return to IDLE, grant=00, buf_full=0, both readies 0.
  - Any window in progress is truncated: dac_valid goes to 0 the next cycle and done does not pulse.
  - last_grant is unchanged.
  - flush together with load_start in the same cycle: flush wins and no window opens.
- Counters:
  - wr_cnt and rd_cnt are CW bits wide and compare against NUM_COLS-1; they never wrap past NUM_COLS.
  - Indexing is buf[cnt], with 8-bit elements.

Test Plan:
- Host burst: r0 supplies bytes 0..127 back-to-back, then load_start → r0_ready is high for 128 cycles, buf_full rises, dac_data=0..127 appears on the cycles after load_start, done pulses on byte 127, grant returns to 00.
- Tie and fairness: r0 and r1 valid together from reset → r0 granted first; after r0 drains, r1 is granted even though r0 is still valid.
- Stall: r1 drops valid for 5 cycles at byte 60 → no byte is lost; buf_full rises 5 cycles later than the uninterrupted case; drained data matches 60 sent bytes and then the remainder in order.
- Underrun: load_start arrives while FILL is at byte 40 → 128 cycles of 8'h80 with underrun pulsing once; the fill completes, and the next load_start drains the real data.
- Flush: flush asserted at drain byte 50 → dac_valid is 0 the next cycle, no done pulse, grant=00, a new grant follows if any requester is valid.
- Reset during FILL at byte 100 → all outputs at their reset values the next cycle; a subsequent full burst drains correctly.

Source files
------------

// File: rtl/dac_gain_arbiter_if.sv
// rtl/dac_gain_arbiter_if.sv - requester, controller and DAC signal bundle for dac_gain_arbiter
interface dac_gain_arbiter_if;
    logic       r0_valid;
    logic [7:0] r0_data;
    logic       r0_ready;
    logic       r1_valid;
    logic [7:0] r1_data;
    logic       r1_ready;
    logic       load_start;
    logic       flush;
    logic [7:0] dac_data;
    logic       dac_valid;
    logic [1:0] grant;
    logic       buf_full;
    logic       done;
    logic       underrun;

    modport master (
        output r0_valid, r0_data,
        input  r0_ready,
        output r1_valid, r1_data,
        input  r1_ready,
        output load_start, flush,
        input  dac_data, dac_valid, grant, buf_full, done, underrun
    );

    modport slave (
        input  r0_valid, r0_data,
        output r0_ready,
        input  r1_valid, r1_data,
        output r1_ready,
        input  load_start, flush,
        output dac_data, dac_valid, grant, buf_full, done, underrun
    );
endinterface

// File: rtl/dac_gain_arbiter.sv
// rtl/dac_gain_arbiter.sv - two-requester gain burst buffer replayed into the DAC load window
module dac_gain_arbiter #(
    parameter int         NUM_COLS     = 128,
    parameter logic [7:0] DEFAULT_CODE = 8'h80,
    parameter int         CW           = 8
) (
    input  logic              clk,
    input  logic              reset,
    dac_gain_arbiter_if.slave bus
);
    localparam int            AW         = $clog2(NUM_COLS);
    localparam logic [CW-1:0] LAST_IDX   = CW'(NUM_COLS - 1);
    localparam logic [CW-1:0] PENULT_IDX = CW'(NUM_COLS - 2);

    typedef enum logic [1:0] {IDLE, FILL, ARMED, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [1:0]    grant_q, grant_nxt;
    logic          last_r1_q, last_r1_nxt;
    logic          buf_full_q, buf_full_nxt;
    logic [CW-1:0] wr_cnt, wr_cnt_nxt;
    logic [CW-1:0] rd_cnt, rd_cnt_nxt;
    logic          win_q, win_nxt;
    logic          win_dflt_q, win_dflt_nxt;
    logic          done_q, done_nxt;
    logic          underrun_q, underrun_nxt;
    logic [7:0]    dac_data_q;
    logic [7:0]    gain_buf [NUM_COLS];

    logic          accept;
    logic          pick_r0;
    logic          pick_r1;
    logic          win_open;
    logic          win_last;
    logic [7:0]    wr_data;

    always_comb begin
        accept   = (state == FILL) &&
                   ((grant_q[0] && bus.r0_valid) || (grant_q[1] && bus.r1_valid));
        wr_data  = grant_q[1] ? bus.r1_data : bus.r0_data;
        // On a tie the requester that did not own the previous burst wins.
        pick_r0  = bus.r0_valid && (!bus.r1_valid || last_r1_q);
        pick_r1  = bus.r1_valid && !pick_r0;
        win_open = bus.load_start && !win_q;
        win_last = win_q && (rd_cnt == LAST_IDX);
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_q;
        last_r1_nxt  = last_r1_q;
        buf_full_nxt = buf_full_q;
        wr_cnt_nxt   = wr_cnt;
        rd_cnt_nxt   = rd_cnt;
        win_nxt      = win_q;
        win_dflt_nxt = win_dflt_q;
        done_nxt     = 1'b0;
        underrun_nxt = 1'b0;

        // The window runs independently so a default window can overlap a fill.
        if (win_q) begin
            done_nxt = (rd_cnt == PENULT_IDX);
            if (win_last) begin
                win_nxt = 1'b0;
            end else begin
                rd_cnt_nxt = rd_cnt + CW'(1);
            end
        end else if (win_open) begin
            win_nxt      = 1'b1;
            rd_cnt_nxt   = '0;
            win_dflt_nxt = (state != ARMED);
            underrun_nxt = (state != ARMED);
        end

        case (state)
            IDLE: begin
                if (pick_r0 || pick_r1) begin
                    state_nxt  = FILL;
                    grant_nxt  = {pick_r1, pick_r0};
                    wr_cnt_nxt = '0;
                end
            end
            FILL: begin
                if (accept) begin
                    if (wr_cnt == LAST_IDX) begin
                        state_nxt    = ARMED;
                        buf_full_nxt = 1'b1;
                        last_r1_nxt  = grant_q[1];
                        wr_cnt_nxt   = '0;
                    end else begin
                        wr_cnt_nxt = wr_cnt + CW'(1);
                    end
                end
            end
            ARMED: begin
                if (win_open) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (win_last) begin
                    state_nxt    = IDLE;
                    grant_nxt    = 2'b00;
                    buf_full_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (bus.flush) begin
            state_nxt    = IDLE;
            grant_nxt    = 2'b00;
            last_r1_nxt  = last_r1_q;
            buf_full_nxt = 1'b0;
            wr_cnt_nxt   = '0;
            rd_cnt_nxt   = '0;
            win_nxt      = 1'b0;
            win_dflt_nxt = 1'b0;
            done_nxt     = 1'b0;
            underrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            last_r1_q  <= 1'b1;
            buf_full_q <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            win_q      <= 1'b0;
            win_dflt_q <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            dac_data_q <= 8'h00;
        end else begin
            state      <= state_nxt;
            grant_q    <= grant_nxt;
            last_r1_q  <= last_r1_nxt;
            buf_full_q <= buf_full_nxt;
            wr_cnt     <= wr_cnt_nxt;
            rd_cnt     <= rd_cnt_nxt;
            win_q      <= win_nxt;
            win_dflt_q <= win_dflt_nxt;
            done_q     <= done_nxt;
            underrun_q <= underrun_nxt;
            // dac_data holds its last value whenever the window is closed.
            if (win_nxt) begin
                dac_data_q <= win_dflt_nxt ? DEFAULT_CODE : gain_buf[rd_cnt_nxt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            gain_buf[wr_cnt[AW-1:0]] <= wr_data;
        end
    end

    assign bus.r0_ready  = (state == FILL) && grant_q[0];
    assign bus.r1_ready  = (state == FILL) && grant_q[1];
    assign bus.grant     = grant_q;
    assign bus.buf_full  = buf_full_q;
    assign bus.dac_valid = win_q;
    assign bus.dac_data  = dac_data_q;
    assign bus.done      = done_q;
    assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_dac_gain_arbiter.sv
// tb/tb_dac_gain_arbiter.sv - self-checking bench for dac_gain_arbiter against a burst-level model
module tb_dac_gain_arbiter;
    localparam int         NUM  = 128;
    localparam logic [7:0] DEFC = 8'h80;

    logic clk;
    logic reset;
    dac_gain_arbiter_if bus ();

    dac_gain_arbiter #(.NUM_COLS(NUM), .DEFAULT_CODE(DEFC), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_fill[$];
    logic [7:0] m_buf[$];
    logic [7:0] exp_win[$];
    int         m_owner;
    int         m_last;
    bit         m_full;
    bit         m_drain;
    bit         cur_valid;
    logic [7:0] m_dac;
    int         seen_done;
    int         seen_under;
    int         rdy0_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Advance one clock: update the burst-level model from this cycle's inputs, then check the new cycle.
    task automatic step();
        bit         under_next;
        bit         acc;
        bit         drain_end;
        bit         want_done;
        logic [1:0] want_grant;
        under_next = 1'b0;
        if (reset) begin
            m_fill.delete(); m_buf.delete(); exp_win.delete();
            m_owner = 0; m_last = 2; m_full = 0; m_drain = 0; m_dac = 8'h00;
        end else if (bus.flush) begin
            m_fill.delete(); exp_win.delete();
            m_owner = 0; m_full = 0; m_drain = 0;
        end else begin
            acc       = !m_full && ((m_owner == 1 && bus.r0_valid) || (m_owner == 2 && bus.r1_valid));
            drain_end = m_drain && cur_valid && exp_win.size() == 0;
            if (bus.load_start && !cur_valid) begin
                if (m_full) begin
                    exp_win = m_buf;
                    m_drain = 1;
                end else begin
                    for (int i = 0; i < NUM; i++) exp_win.push_back(DEFC);
                    under_next = 1'b1;
                end
            end
            if (m_owner == 0) begin
                if (bus.r0_valid && bus.r1_valid) m_owner = (m_last == 1) ? 2 : 1;
                else if (bus.r0_valid)            m_owner = 1;
                else if (bus.r1_valid)            m_owner = 2;
            end else if (acc) begin
                m_fill.push_back(m_owner == 1 ? bus.r0_data : bus.r1_data);
                if (m_fill.size() == NUM) begin
                    m_buf = m_fill;
                    m_fill.delete();
                    m_full = 1;
                    m_last = m_owner;
                end
            end
            if (drain_end) begin
                m_owner = 0; m_full = 0; m_drain = 0;
            end
        end

        @(posedge clk);
        #1;

        if (exp_win.size() > 0) begin
            cur_valid = 1;
            m_dac     = exp_win.pop_front();
            want_done = (exp_win.size() == 0);
        end else begin
            cur_valid = 0;
            want_done = 0;
        end
        want_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        chk("dac_valid", bus.dac_valid, cur_valid);
        chk("dac_data",  bus.dac_data,  m_dac);
        chk("done",      bus.done,      want_done);
        chk("underrun",  bus.underrun,  under_next);
        chk("grant",     bus.grant,     want_grant);
        chk("buf_full",  bus.buf_full,  m_full);
        chk("r0_ready",  bus.r0_ready,  (m_owner == 1 && !m_full));
        chk("r1_ready",  bus.r1_ready,  (m_owner == 2 && !m_full));
        if (bus.done)     seen_done++;
        if (bus.underrun) seen_under++;
        if (bus.r0_ready) rdy0_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic window();
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
    endtask

    task automatic fill_burst(input int who, input int stall_at, input int stall_len,
                              input int ls_at, input bit seq_data, output int cyc);
        int         stalled;
        bit         ls_done;
        bit         v;
        logic [7:0] d;
        stalled = 0;
        ls_done = 0;
        cyc     = 0;
        while (!m_full && cyc < 1000) begin
            v = 1'b1;
            if (m_fill.size() == stall_at && stalled < stall_len) begin
                v = 1'b0;
                stalled++;
            end
            d = seq_data ? 8'(m_fill.size()) : 8'($urandom);
            if (who == 1) begin bus.r0_valid = v; bus.r0_data = d; end
            else          begin bus.r1_valid = v; bus.r1_data = d; end
            if (ls_at >= 0 && !ls_done && m_fill.size() == ls_at) begin
                bus.load_start = 1'b1;
                ls_done = 1;
            end
            step();
            bus.load_start = 1'b0;
            cyc++;
        end
        chk("fill_complete", m_full, 1'b1);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        bus.r0_valid = 1'b0; bus.r0_data = 8'h00;
        bus.r1_valid = 1'b0; bus.r1_data = 8'h00;
        bus.load_start = 1'b0; bus.flush = 1'b0;
        cur_valid = 0; seen_done = 0; seen_under = 0; rdy0_cnt = 0;
        step();
        reset = 1'b0;
        chk("reset_grant",    bus.grant,    2'b00);
        chk("reset_dac_data", bus.dac_data, 8'h00);

        // Host burst 0..127 and drain.
        rdy0_cnt = 0;
        fill_burst(1, -1, 0, -1, 1, cyc);
        chk("host_fill_cycles", cyc, NUM + 1);
        chk("host_ready_cycles", rdy0_cnt, NUM);
        bus.r0_valid = 1'b0;
        idle(2);
        seen_done = 0;
        window();
        idle(NUM + 1);
        chk("host_done_once", seen_done, 1);
        chk("host_grant_released", bus.grant, 2'b00);

        // Tie from reset, then fairness while r0 stays valid.
        pulse_reset();
        bus.r1_valid = 1'b1; bus.r1_data = 8'($urandom);
        fill_burst(1, -1, 0, -1, 0, cyc);
        chk("tie_r0_first", bus.grant, 2'b01);
        window();
        idle(NUM + 1);
        chk("fair_r1_next", bus.grant, 2'b10);
        fill_burst(2, -1, 0, -1, 0, cyc);
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        window();
        idle(NUM + 2);

        // r1 stalls five cycles at byte 60.
        fill_burst(2, 60, 5, -1, 0, cyc);
        chk("stall_full_cycle", cyc, NUM + 6);
        bus.r1_valid = 1'b0;
        window();
        idle(NUM + 2);

        // load_start during fill at byte 40 gives a default window.
        seen_under = 0; seen_done = 0;
        fill_burst(1, -1, 0, 40, 0, cyc);
        bus.r0_valid = 1'b0;
        idle(NUM);
        chk("underrun_once", seen_under, 1);
        chk("underrun_done", seen_done, 1);
        window();
        idle(NUM + 2);
        chk("after_underrun_done", seen_done, 2);
        chk("after_underrun_pulses", seen_under, 1);

        // Flush at drain byte 50 with r1 waiting.
        fill_burst(1, -1, 0, -1, 0, cyc);
        bus.r0_valid = 1'b0;
        seen_done = 0;
        window();
        idle(50);
        bus.r1_valid = 1'b1; bus.r1_data = 8'($urandom);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_valid", bus.dac_valid, 1'b0);
        chk("flush_grant", bus.grant, 2'b00);
        step();
        chk("flush_regrant", bus.grant, 2'b10);
        chk("flush_no_done", seen_done, 0);

        // Reset in the middle of an r1 fill at byte 100.
        cyc = 0;
        while (m_fill.size() < 100 && cyc < 300) begin
            bus.r1_data = 8'($urandom);
            step();
            cyc++;
        end
        chk("reach_byte_100", m_fill.size(), 100);
        pulse_reset();
        chk("midfill_reset_grant", bus.grant, 2'b00);
        chk("midfill_reset_ready", bus.r1_ready, 1'b0);
        seen_done = 0;
        fill_burst(1, -1, 0, -1, 0, cyc);
        bus.r0_valid = 1'b0;
        window();
        idle(NUM + 2);
        chk("final_done", seen_done, 1);
        chk("final_buf_full", bus.buf_full, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
